// File: rtl/apb_mem_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | apb_mem_pkg : shared types and width helpers for the APB memory slave        |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
package apb_mem_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      READY = 2'd2
   } state_t;

   localparam int MAX_WAIT = 15;
   localparam int CNT_W    = $clog2(MAX_WAIT + 1);

   function automatic int strb_w(input int data_width);
      return data_width / 8;
   endfunction

   function automatic int ofs_w(input int data_width);
      return $clog2(data_width / 8);
   endfunction

endpackage
`default_nettype wire

// File: rtl/apb_mem_array.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | apb_mem_array : byte-lane RAM with async clear, strobed write, sync read     |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
module apb_mem_array
   import apb_mem_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 1024,
   parameter int IDX_W      = 10
) (
   input  logic                          pclk,
   input  logic                          PRESETn,
   input  logic                          we,
   input  logic [strb_w(DATA_WIDTH)-1:0] be,
   input  logic [IDX_W-1:0]              waddr,
   input  logic [DATA_WIDTH-1:0]         wdata,
   input  logic                          re,
   input  logic [IDX_W-1:0]              raddr,
   output logic [DATA_WIDTH-1:0]         rdata
);

   localparam int STRB_W = strb_w(DATA_WIDTH);

   // One independent byte-wide array per lane keeps the strobed write free of read-modify-write.
   // The read register returns zero whenever no read is requested, so it can drive the bus directly.
   generate
      for (genvar l = 0; l < STRB_W; l++) begin : g_lane
         logic [7:0] mem [DEPTH];
         logic [7:0] rd_byte;

         always_ff @(posedge pclk or negedge PRESETn) begin
            if (!PRESETn) begin
               for (int i = 0; i < DEPTH; i++) begin
                  mem[i] <= 8'h00;
               end
               rd_byte <= 8'h00;
            end else begin
               if (we && be[l]) begin
                  mem[waddr] <= wdata[8*l +: 8];
               end
               rd_byte <= re ? mem[raddr] : 8'h00;
            end
         end

         assign rdata[8*l +: 8] = rd_byte;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/apb_mem_ws.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | apb_mem_ws : APB4 memory slave with byte strobes, error response, wait states|
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
module apb_mem_ws
   import apb_mem_pkg::*;
#(
   parameter int ADDR_WIDTH  = 12,
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 1024,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                    pclk,
   input  logic                    PRESETn,
   input  logic [ADDR_WIDTH-1:0]   paddr,
   input  logic                    pwrite,
   input  logic                    psel,
   input  logic                    penable,
   input  logic [DATA_WIDTH-1:0]   pwdata,
   input  logic [DATA_WIDTH/8-1:0] pstrb,
   output logic [DATA_WIDTH-1:0]   prdata,
   output logic                    pready,
   output logic                    pslverr
);

   localparam int OFS_W = ofs_w(DATA_WIDTH);
   localparam int IW    = ADDR_WIDTH - OFS_W;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [IW:0]      DEPTH_V   = (IW + 1)'(DEPTH);
   localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] lat_idx;
   logic             lat_write;
   logic             lat_err;

   logic [IW-1:0]    idx;
   logic             misalign;
   logic             addr_err;
   logic             setup;
   logic             mem_we;
   logic             mem_re;
   logic [IDX_W-1:0] mem_raddr;

   assign idx   = paddr[ADDR_WIDTH-1:OFS_W];
   assign setup = psel && !penable;

   generate
      if (OFS_W > 0) begin : g_ofs
         assign misalign = |paddr[(OFS_W > 0 ? OFS_W - 1 : 0):0];
      end else begin : g_no_ofs
         assign misalign = 1'b0;
      end
   endgenerate

   // Out-of-range indices error out instead of aliasing onto existing words.
   assign addr_err = misalign || ({1'b0, idx} >= DEPTH_V);

   // The read is issued on the edge that enters READY so data is stable for the whole READY cycle.
   always_comb begin
      mem_re    = 1'b0;
      mem_raddr = lat_idx;
      if (state == IDLE && setup && WAIT_CYCLES == 0) begin
         mem_re    = !pwrite && !addr_err;
         mem_raddr = idx[IDX_W-1:0];
      end else if (state == WAIT && psel && cnt == CNT_W'(1)) begin
         mem_re    = !lat_write && !lat_err;
      end
   end

   assign mem_we = (state == READY) && psel && penable && lat_write && !lat_err;

   always_ff @(posedge pclk or negedge PRESETn) begin
      if (!PRESETn) begin
         state     <= IDLE;
         cnt       <= '0;
         lat_idx   <= '0;
         lat_write <= 1'b0;
         lat_err   <= 1'b0;
         pready    <= 1'b0;
         pslverr   <= 1'b0;
      end else begin
         pready  <= 1'b0;
         pslverr <= 1'b0;
         case (state)
            IDLE: begin
               if (setup) begin
                  lat_idx   <= idx[IDX_W-1:0];
                  lat_write <= pwrite;
                  lat_err   <= addr_err;
                  if (WAIT_CYCLES == 0) begin
                     state   <= READY;
                     pready  <= 1'b1;
                     pslverr <= addr_err;
                  end else begin
                     state <= WAIT;
                     cnt   <= WAIT_INIT;
                  end
               end
            end
            WAIT: begin
               if (!psel) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt - CNT_W'(1);
                  if (cnt == CNT_W'(1)) begin
                     state   <= READY;
                     pready  <= 1'b1;
                     pslverr <= lat_err;
                  end
               end
            end
            READY: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   apb_mem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .IDX_W      (IDX_W)
   ) u_array (
      .pclk    (pclk),
      .PRESETn (PRESETn),
      .we      (mem_we),
      .be      (pstrb),
      .waddr   (lat_idx),
      .wdata   (pwdata),
      .re      (mem_re),
      .raddr   (mem_raddr),
      .rdata   (prdata)
   );

endmodule
`default_nettype wire

// File: tb/tb_apb_mem_ws.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_apb_mem_ws : bench for apb_mem_ws, two wait-state configurations          |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
module tb_apb_mem_ws;

   logic        pclk;
   logic        PRESETn;
   logic [12:0] paddr;
   logic        pwrite;
   logic        psel_a;
   logic        psel_b;
   logic        penable;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [31:0] prdata_a, prdata_b;
   logic        pready_a, pready_b;
   logic        pslverr_a, pslverr_b;

   int checks = 0;
   int errors = 0;
   logic [31:0] last_rd;
   logic        last_err;
   logic [31:0] m2 [int];
   logic [31:0] m0 [int];

   // A 13-bit address makes 0x1000 (word 1024) reachable as an out-of-range access.
   apb_mem_ws #(.ADDR_WIDTH(13), .DATA_WIDTH(32), .DEPTH(1024), .WAIT_CYCLES(2)) dut_ws2 (
      .pclk(pclk), .PRESETn(PRESETn), .paddr(paddr), .pwrite(pwrite), .psel(psel_a),
      .penable(penable), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_a),
      .pready(pready_a), .pslverr(pslverr_a));

   apb_mem_ws #(.ADDR_WIDTH(13), .DATA_WIDTH(32), .DEPTH(1024), .WAIT_CYCLES(0)) dut_ws0 (
      .pclk(pclk), .PRESETn(PRESETn), .paddr(paddr), .pwrite(pwrite), .psel(psel_b),
      .penable(penable), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_b),
      .pready(pready_b), .pslverr(pslverr_b));

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic bus_idle();
      @(posedge pclk); #1;
      psel_a  = 1'b0;
      psel_b  = 1'b0;
      penable = 1'b0;
   endtask

   // Drives one APB transfer; checks bus outputs stay zero until pready, bounded to 20 cycles.
   task automatic xfer(input bit ws0, input logic [12:0] addr, input bit wr,
                       input logic [31:0] wd, input logic [3:0] st,
                       output logic [31:0] rd, output logic err, output int lat);
      @(posedge pclk); #1;
      paddr   = addr;
      pwrite  = wr;
      pwdata  = wd;
      pstrb   = st;
      penable = 1'b0;
      psel_a  = !ws0;
      psel_b  = ws0;
      @(posedge pclk); #1;
      penable = 1'b1;
      lat = 0;
      rd  = '0;
      err = 1'bx;
      for (int n = 1; n <= 20 && lat == 0; n++) begin
         @(negedge pclk);
         if ((ws0 ? pready_b : pready_a) === 1'b1) begin
            lat = n;
            rd  = ws0 ? prdata_b : prdata_a;
            err = ws0 ? pslverr_b : pslverr_a;
         end else begin
            check("wait_outputs_zero",
                  64'({(ws0 ? pslverr_b : pslverr_a), (ws0 ? prdata_b : prdata_a)}), 64'h0);
         end
      end
   endtask

   // Reference model: word-indexed sparse memory, byte-merged writes, error on range/alignment.
   task automatic step(input bit ws0, input logic [12:0] addr, input bit wr,
                       input logic [31:0] wd, input logic [3:0] st, input string tag);
      int          idx;
      logic        exp_err;
      logic [31:0] old_w, new_w, exp_rd, rd;
      logic        err;
      int          lat;
      idx     = int'(addr) / 4;
      exp_err = (idx >= 1024) || (int'(addr) % 4 != 0);
      if (ws0) old_w = m0.exists(idx) ? m0[idx] : 32'h0;
      else     old_w = m2.exists(idx) ? m2[idx] : 32'h0;
      new_w = old_w;
      for (int b = 0; b < 4; b++) begin
         if (st[b]) new_w[8*b +: 8] = wd[8*b +: 8];
      end
      exp_rd = (wr || exp_err) ? 32'h0 : old_w;
      if (wr && !exp_err) begin
         if (ws0) m0[idx] = new_w;
         else     m2[idx] = new_w;
      end
      xfer(ws0, addr, wr, wd, st, rd, err, lat);
      check({tag, "_latency"}, 64'(lat), ws0 ? 64'd1 : 64'd3);
      check({tag, "_pslverr"}, 64'(err), 64'(exp_err));
      check({tag, "_prdata"}, 64'(rd), 64'(exp_rd));
      last_rd  = rd;
      last_err = err;
   endtask

   initial begin
      PRESETn = 1'b0;
      psel_a  = 1'b0;
      psel_b  = 1'b0;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = '0;
      pwdata  = '0;
      pstrb   = '0;
      repeat (2) @(posedge pclk);
      @(negedge pclk);
      check("reset_outputs_ws2", 64'({pready_a, pslverr_a, prdata_a}), 64'h0);
      check("reset_outputs_ws0", 64'({pready_b, pslverr_b, prdata_b}), 64'h0);
      @(posedge pclk); #1;
      PRESETn = 1'b1;

      step(0, 13'h010, 1'b0, 32'h0, 4'h0, "rd010");
      check("rd010_value", 64'(last_rd), 64'h0);

      step(0, 13'h004, 1'b1, 32'hDEADBEEF, 4'hF, "wr004_full");
      step(0, 13'h004, 1'b0, 32'h0, 4'h0, "rd004_full");
      check("rd004_full_value", 64'(last_rd), 64'hDEADBEEF);
      step(0, 13'h000, 1'b0, 32'h0, 4'h0, "rd000");
      check("rd000_value", 64'(last_rd), 64'h0);
      step(0, 13'h008, 1'b0, 32'h0, 4'h0, "rd008");
      check("rd008_value", 64'(last_rd), 64'h0);

      step(0, 13'h004, 1'b1, 32'h11223344, 4'b0101, "wr004_strb");
      step(0, 13'h004, 1'b0, 32'h0, 4'h0, "rd004_strb");
      check("rd004_strb_value", 64'(last_rd), 64'hDE22BE44);

      step(0, 13'h1000, 1'b1, 32'hCAFEF00D, 4'hF, "wr_oor");
      check("wr_oor_err", 64'(last_err), 64'h1);
      step(0, 13'h006, 1'b1, 32'hCAFEF00D, 4'hF, "wr_misalign");
      check("wr_misalign_err", 64'(last_err), 64'h1);
      step(0, 13'h004, 1'b0, 32'h0, 4'h0, "rd004_after_err");
      check("rd004_after_err_value", 64'(last_rd), 64'hDE22BE44);
      step(0, 13'h1000, 1'b0, 32'h0, 4'h0, "rd_oor");
      check("rd_oor_err", 64'(last_err), 64'h1);
      check("rd_oor_value", 64'(last_rd), 64'h0);
      bus_idle();

      // psel dropped mid-WAIT: no completion, no write
      @(posedge pclk); #1;
      paddr = 13'h030; pwrite = 1'b1; pwdata = 32'h12345678; pstrb = 4'hF;
      psel_a = 1'b1; psel_b = 1'b0; penable = 1'b0;
      @(posedge pclk); #1;
      penable = 1'b1;
      @(posedge pclk); #1;
      psel_a  = 1'b0;
      penable = 1'b0;
      repeat (3) begin
         @(negedge pclk);
         check("abort_pready", 64'(pready_a), 64'h0);
      end
      step(0, 13'h030, 1'b0, 32'h0, 4'h0, "abort_rd");
      check("abort_rd_value", 64'(last_rd), 64'h0);

      for (int k = 0; k < 60; k++) begin
         int r;
         int ix;
         logic [12:0] a;
         r  = int'($urandom_range(0, 9));
         ix = (r == 0) ? int'($urandom_range(1020, 1030)) : int'($urandom_range(0, 15));
         a  = 13'(ix * 4);
         if (r == 1) a[1:0] = 2'($urandom_range(1, 3));
         step(0, a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), "rnd_ws2");
      end
      bus_idle();

      step(1, 13'h3FC, 1'b1, 32'h000000A5, 4'hF, "b2b_wr");
      step(1, 13'h3FC, 1'b0, 32'h0, 4'h0, "b2b_rd");
      check("b2b_rd_value", 64'(last_rd), 64'hA5);
      for (int k = 0; k < 20; k++) begin
         logic [12:0] a;
         a = 13'($urandom_range(1018, 1023) * 4);
         if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
         step(1, a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), "rnd_ws0");
      end
      bus_idle();

      // Reset asserted while a write sits in WAIT
      @(posedge pclk); #1;
      paddr = 13'h020; pwrite = 1'b1; pwdata = 32'h55AA55AA; pstrb = 4'hF;
      psel_a = 1'b1; psel_b = 1'b0; penable = 1'b0;
      @(posedge pclk); #1;
      penable = 1'b1;
      @(negedge pclk);
      PRESETn = 1'b0;
      #1;
      check("midrst_outputs", 64'({pready_a, pslverr_a, prdata_a}), 64'h0);
      psel_a  = 1'b0;
      penable = 1'b0;
      m2.delete();
      m0.delete();
      @(posedge pclk); #1;
      PRESETn = 1'b1;
      step(0, 13'h020, 1'b0, 32'h0, 4'h0, "post_rst_rd020");
      check("post_rst_rd020_value", 64'(last_rd), 64'h0);
      step(0, 13'h004, 1'b0, 32'h0, 4'h0, "post_rst_rd004");
      check("post_rst_rd004_value", 64'(last_rd), 64'h0);
      step(1, 13'h3FC, 1'b0, 32'h0, 4'h0, "post_rst_rd3fc");
      check("post_rst_rd3fc_value", 64'(last_rd), 64'h0);
      bus_idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
